// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the CPU memory port: strobes, address and handshakes.
// The bidirectional data bus stays a plain inout on the arbiter so the
// tristate resolution happens on an ordinary net.
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 inputReady;
    logic                 ackOutput;

    modport master (
        output readM,
        output writeM,
        output address,
        input  inputReady,
        input  ackOutput
    );

    modport slave (
        input  readM,
        input  writeM,
        input  address,
        output inputReady,
        output ackOutput
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single CPU memory port between instruction fetch and load/store.
// Each access is one registered bus transaction with a bounded wait for the
// memory handshake; an expired wait completes the access with zero data and
// raises a sticky error flag.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_done,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    mem_port_arbiter_if.master   mem,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        RD_I,
        RD_D,
        WR_D
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t               state_q, state_d;
    logic                 last_d_q, last_d_d;
    logic [7:0]           wcnt_q, wcnt_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic                 if_done_d, d_done_d;
    logic [WORD_SIZE-1:0] if_rdata_d, d_rdata_d;
    logic                 busy_d, timeout_err_d;

    assign mem.readM   = read_q;
    assign mem.writeM  = write_q;
    assign mem.address = addr_q;

    // Store data is on the bus only while the write strobe is asserted.
    assign data = write_q ? wdata_q : 'z;

    // Next-state logic: arbitration in IDLE, handshake/timeout in access states.
    always_comb begin
        state_d       = state_q;
        last_d_d      = last_d_q;
        wcnt_d        = wcnt_q;
        wdata_d       = wdata_q;
        addr_d        = addr_q;
        read_d        = 1'b0;
        write_d       = 1'b0;
        if_done_d     = 1'b0;
        d_done_d      = 1'b0;
        if_rdata_d    = if_rdata;
        d_rdata_d     = d_rdata;
        timeout_err_d = timeout_err;

        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                // On contention the requester that did not win last time goes first.
                if (d_req && (!if_req || !last_d_q)) begin
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    last_d_d = 1'b1;
                    if (d_we) begin
                        state_d = WR_D;
                        write_d = 1'b1;
                    end else begin
                        state_d = RD_D;
                        read_d  = 1'b1;
                    end
                end else if (if_req) begin
                    addr_d   = if_addr;
                    last_d_d = 1'b0;
                    state_d  = RD_I;
                    read_d   = 1'b1;
                end
            end

            RD_I, RD_D: begin
                if (mem.inputReady) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                    if (state_q == RD_I) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = data;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = data;
                    end
                end else if (wcnt_q == TIMEOUT_CNT) begin
                    state_d       = IDLE;
                    wcnt_d        = '0;
                    timeout_err_d = 1'b1;
                    if (state_q == RD_I) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    read_d = 1'b1;
                    wcnt_d = wcnt_q + 8'd1;
                end
            end

            WR_D: begin
                if (mem.ackOutput) begin
                    state_d  = IDLE;
                    wcnt_d   = '0;
                    d_done_d = 1'b1;
                end else if (wcnt_q == TIMEOUT_CNT) begin
                    state_d       = IDLE;
                    wcnt_d        = '0;
                    d_done_d      = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    write_d = 1'b1;
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset silently abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            wcnt_q      <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            wcnt_q      <= wcnt_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            if_done     <= if_done_d;
            d_done      <= d_done_d;
            if_rdata    <= if_rdata_d;
            d_rdata     <= d_rdata_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the basic
// fetch, store and alternation traffic, then hand-written timeout and reset
// sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        busy;
    logic        timeout_err;
    logic [15:0] mem_rdata;
    wire  [15:0] data;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter_if #(.WORD_SIZE(16)) mem ();

    mem_port_arbiter #(
        .WORD_SIZE(16),
        .TIMEOUT  (255)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .mem        (mem.master),
        .data       (data),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // Memory model drives read data onto the bus while the read strobe is high.
    assign data = mem.readM ? mem_rdata : 'z;

    always #5 clk = ~clk;

    // ctl = {reset_n, if_req, d_req, d_we, inputReady, ackOutput}
    // ef  = {readM, writeM, if_done, d_done, busy} expected after the edge
    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] ia;
        logic [15:0] da;
        logic [15:0] dw;
        logic [15:0] md;
        logic [4:0]  ef;
        logic [15:0] ea;
        logic [15:0] eir;
        logic [15:0] edr;
        logic [15:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic [5:0] ctl, input logic [15:0] ia, input logic [15:0] da,
                     input logic [15:0] dw, input logic [15:0] md, input logic [4:0] ef,
                     input logic [15:0] ea, input logic [15:0] eir, input logic [15:0] edr,
                     input logic [15:0] ed);
        vec_t t;
        t = '{ctl, ia, da, dw, md, ef, ea, eir, edr, ed};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] flags();
        return {mem.readM, mem.writeM, if_done, d_done, busy};
    endfunction

    // Strobes must be exclusive and done pulses must never coincide.
    always @(negedge clk) begin
        checks++;
        if ((mem.readM && mem.writeM) || (if_done && d_done)) begin
            failures++;
            $display("FAIL exclusive actual=%b%b%b%b expected=no_overlap",
                     mem.readM, mem.writeM, if_done, d_done);
        end
    end

    initial begin
        vec_t t;
        int   n;

        reset_n        = 1'b0;
        if_req         = 1'b0;
        if_addr        = '0;
        d_req          = 1'b0;
        d_we           = 1'b0;
        d_addr         = '0;
        d_wdata        = '0;
        mem_rdata      = '0;
        mem.inputReady = 1'b0;
        mem.ackOutput  = 1'b0;

        // Reset
        v(6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        v(6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // Fetch 0010, three strobe cycles, stray ackOutput ignored, data F1C0
        v(6'b110000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 5'b10001, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        v(6'b110001, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 5'b10001, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        v(6'b110000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 5'b10001, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        v(6'b110010, 16'h0010, 16'h0000, 16'h0000, 16'hF1C0, 5'b00100, 16'h0010, 16'hF1C0, 16'h0000, 16'h0000);
        v(6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 16'h0010, 16'hF1C0, 16'h0000, 16'h0000);
        // Store 1234 to 0040; requester inputs change mid-access and must be ignored
        v(6'b101100, 16'h0000, 16'h0040, 16'h1234, 16'h0000, 5'b01001, 16'h0040, 16'hF1C0, 16'h0000, 16'h1234);
        v(6'b101100, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 5'b01001, 16'h0040, 16'hF1C0, 16'h0000, 16'h1234);
        v(6'b101101, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 5'b00010, 16'h0040, 16'hF1C0, 16'h0000, 16'h0000);
        // Handshakes while IDLE are ignored
        v(6'b100011, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 16'h0040, 16'hF1C0, 16'h0000, 16'h0000);
        // Reset clears captured data and the arbitration history
        v(6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        v(6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // Both requesting with immediate handshakes: D, I, D, I
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 5'b10001, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'hAAAA, 5'b00010, 16'h0100, 16'h0000, 16'hAAAA, 16'h0000);
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 5'b10001, 16'h0200, 16'h0000, 16'hAAAA, 16'h0000);
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'hBBBB, 5'b00100, 16'h0200, 16'hBBBB, 16'hAAAA, 16'h0000);
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 5'b10001, 16'h0100, 16'hBBBB, 16'hAAAA, 16'h0000);
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'hCCCC, 5'b00010, 16'h0100, 16'hBBBB, 16'hCCCC, 16'h0000);
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 5'b10001, 16'h0200, 16'hBBBB, 16'hCCCC, 16'h0000);
        v(6'b111010, 16'h0200, 16'h0100, 16'h0000, 16'hDDDD, 5'b00100, 16'h0200, 16'hDDDD, 16'hCCCC, 16'h0000);
        v(6'b100000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 16'h0200, 16'hDDDD, 16'hCCCC, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            {reset_n, if_req, d_req, d_we, mem.inputReady, mem.ackOutput} = t.ctl;
            if_addr   = t.ia;
            d_addr    = t.da;
            d_wdata   = t.dw;
            mem_rdata = t.md;
            tick();
            chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(t.ef));
            chk($sformatf("v%0d_address", i), 32'(mem.address), 32'(t.ea));
            chk($sformatf("v%0d_if_rdata", i), 32'(if_rdata), 32'(t.eir));
            chk($sformatf("v%0d_d_rdata", i), 32'(d_rdata), 32'(t.edr));
            if (t.ef[3]) chk($sformatf("v%0d_data", i), 32'(data), 32'(t.ed));
        end

        // Load with no inputReady: abort on the 256th edge after the grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300; mem.inputReady = 1'b0;
        tick();
        chk("to_grant", 32'(flags()), 32'(5'b10001));
        n = 0;
        while (!d_done && n < 400) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd256);
        chk("to_rdata", 32'(d_rdata), 32'h0);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_flags", 32'(flags()), 32'(5'b00010));
        d_req = 1'b0;
        tick();
        // A good fetch afterwards leaves the error flag set
        if_req = 1'b1; if_addr = 16'h0400;
        tick();
        mem.inputReady = 1'b1; mem_rdata = 16'h5A5A;
        tick();
        chk("after_to_done", 32'(flags()), 32'(5'b00100));
        chk("after_to_rdata", 32'(if_rdata), 32'h5A5A);
        chk("after_to_err", 32'(timeout_err), 32'd1);
        if_req = 1'b0; mem.inputReady = 1'b0;
        tick();

        // Reset during a fetch wait: no done pulse, then a clean re-request
        if_req = 1'b1; if_addr = 16'h0500;
        tick();
        chk("rst_grant", 32'(flags()), 32'(5'b10001));
        tick();
        reset_n = 1'b0; mem.inputReady = 1'b1; mem_rdata = 16'h7777;
        tick();
        chk("rst_flags", 32'(flags()), 32'(5'b00000));
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_rdata", 32'(if_rdata), 32'h0);
        reset_n = 1'b1; if_req = 1'b0; mem.inputReady = 1'b0;
        tick();
        chk("rst_no_done", 32'(flags()), 32'(5'b00000));
        if_req = 1'b1;
        tick();
        chk("rerq_grant", 32'(flags()), 32'(5'b10001));
        chk("rerq_addr", 32'(mem.address), 32'h0500);
        mem.inputReady = 1'b1;
        tick();
        chk("rerq_done", 32'(flags()), 32'(5'b00100));
        chk("rerq_rdata", 32'(if_rdata), 32'h7777);
        if_req = 1'b0; mem.inputReady = 1'b0;
        tick();
        chk("rerq_pulse", 32'(flags()), 32'(5'b00000));

        // Handshake on the same edge the counter sits at TIMEOUT wins
        if_req = 1'b1; if_addr = 16'h0600;
        tick();
        repeat (255) tick();
        chk("edge_wait", 32'(flags()), 32'(5'b10001));
        mem.inputReady = 1'b1; mem_rdata = 16'h6666;
        tick();
        chk("edge_done", 32'(flags()), 32'(5'b00100));
        chk("edge_rdata", 32'(if_rdata), 32'h6666);
        chk("edge_err", 32'(timeout_err), 32'd0);
        if_req = 1'b0; mem.inputReady = 1'b0;
        tick();
        chk("edge_idle", 32'({busy, timeout_err}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
